// File: rtl/gold_pkg.sv
// Shared constants for the gold-sprite engine: grid geometry defaults,
// the reset placement table and the collect handshake state encoding.
package gold_pkg;

    localparam int DEF_N_GOLD = 10;
    localparam int DEF_SPR_W  = 40;
    localparam int DEF_SPR_H  = 40;
    localparam int DEF_X_STEP = 126;
    localparam int DEF_Y_STEP = 108;
    localparam int DEF_X_OFF  = 10;
    localparam int DEF_Y_OFF  = 10;

    // Padded to the 16-slot maximum so slots past the table land on (0,0).
    localparam logic [3:0] DEF_GX [16] = '{4'd2, 4'd1, 4'd7, 4'd8, 4'd5, 4'd6, 4'd2, 4'd9,
                                           4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    localparam logic [2:0] DEF_GY [16] = '{3'd4, 3'd3, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd0,
                                           3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK       = 2'd1,
        ST_WAIT_DROP = 2'd2
    } collect_state_e;

    function automatic logic [10:0] grid_to_x(input logic [3:0] g, input int step, input int off);
        int v;
        v = int'(g) * step + off;
        return v[10:0];
    endfunction

    function automatic logic [9:0] grid_to_y(input logic [2:0] g, input int step, input int off);
        int v;
        v = int'(g) * step + off;
        return v[9:0];
    endfunction

endpackage

// File: rtl/gold_sprite_engine_slot_hit.sv
// Per-slot range test and sprite-local ROM offset for one gold sprite.
module gold_slot_hit
    import gold_pkg::*;
#(
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int ADDR_W = $clog2(SPR_W * SPR_H)
) (
    input  logic [10:0]       curr_x,
    input  logic [9:0]        curr_y,
    input  logic              pix_valid,
    input  logic              active,
    input  logic [10:0]       pos_x,
    input  logic [9:0]        pos_y,
    output logic              in_range,
    output logic [ADDR_W-1:0] off_addr
);

    logic              x_in_s;
    logic              y_in_s;
    logic [ADDR_W-1:0] dx_s;
    logic [ADDR_W-1:0] dy_s;

    // One extra bit on each compare keeps pos+size from wrapping at the screen edge.
    always_comb begin
        x_in_s   = ({1'b0, curr_x} >= {1'b0, pos_x}) &&
                   ({1'b0, curr_x} <  ({1'b0, pos_x} + 12'(SPR_W)));
        y_in_s   = ({1'b0, curr_y} >= {1'b0, pos_y}) &&
                   ({1'b0, curr_y} <  ({1'b0, pos_y} + 11'(SPR_H)));
        in_range = pix_valid && active && x_in_s && y_in_s;
        dx_s     = ADDR_W'(curr_x - pos_x);
        dy_s     = ADDR_W'(curr_y - {1'b0, pos_y[9:0]});
        off_addr = dx_s + ADDR_W'(SPR_W) * dy_s;
    end

endmodule

// File: rtl/gold_sprite_engine.sv
// Gold-sprite position table, collect/respawn bookkeeping and the
// registered hit / ROM-address stage feeding the pixel mux.
module gold_sprite_engine
    import gold_pkg::*;
#(
    parameter int N_GOLD = DEF_N_GOLD,
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int X_STEP = DEF_X_STEP,
    parameter int Y_STEP = DEF_Y_STEP,
    parameter int X_OFF  = DEF_X_OFF,
    parameter int Y_OFF  = DEF_Y_OFF,
    parameter int IDX_W  = (N_GOLD > 1) ? $clog2(N_GOLD) : 1,
    parameter int ADDR_W = $clog2(SPR_W * SPR_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       curr_x,
    input  logic [9:0]        curr_y,
    input  logic              pix_valid,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [3:0]        cfg_gx,
    input  logic [2:0]        cfg_gy,
    input  logic              collect_req,
    input  logic [IDX_W-1:0]  collect_idx,
    output logic              collect_ack,
    input  logic              respawn,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [N_GOLD-1:0] active_mask,
    output logic [IDX_W:0]    remaining
);

    logic [10:0]       pos_x_q [N_GOLD];
    logic [10:0]       pos_x_d [N_GOLD];
    logic [9:0]        pos_y_q [N_GOLD];
    logic [9:0]        pos_y_d [N_GOLD];
    logic [N_GOLD-1:0] active_q, active_d;
    logic [IDX_W:0]    remaining_q, remaining_d;
    collect_state_e    state_q, state_d;
    logic              collect_ack_q, collect_ack_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [N_GOLD-1:0] in_range_s;
    logic [ADDR_W-1:0] off_addr_s [N_GOLD];

    for (genvar g = 0; g < N_GOLD; g++) begin : g_slot
        gold_slot_hit #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_slot_hit (
            .curr_x    (curr_x),
            .curr_y    (curr_y),
            .pix_valid (pix_valid),
            .active    (active_q[g]),
            .pos_x     (pos_x_q[g]),
            .pos_y     (pos_y_q[g]),
            .in_range  (in_range_s[g]),
            .off_addr  (off_addr_s[g])
        );
    end

    // Grid-to-pixel conversion happens once here, on the write.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (cfg_we && (int'(cfg_idx) < N_GOLD)) begin
            pos_x_d[cfg_idx] = grid_to_x(cfg_gx, X_STEP, X_OFF);
            pos_y_d[cfg_idx] = grid_to_y(cfg_gy, Y_STEP, Y_OFF);
        end else begin
            pos_x_d = pos_x_q;
        end
    end

    // Collect handshake; respawn overrides everything, including a same-cycle collect.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        remaining_d   = remaining_q;
        collect_ack_d = 1'b0;
        if (respawn) begin
            active_d    = {N_GOLD{1'b1}};
            remaining_d = (IDX_W + 1)'(N_GOLD);
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (collect_req) begin
                        collect_ack_d = 1'b1;
                        state_d       = ST_ACK;
                        if ((int'(collect_idx) < N_GOLD) && active_q[collect_idx]) begin
                            active_d[collect_idx] = 1'b0;
                            remaining_d = remaining_q - {{IDX_W{1'b0}}, 1'b1};
                        end else begin
                            remaining_d = remaining_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACK: state_d = ST_WAIT_DROP;
                ST_WAIT_DROP: begin
                    if (!collect_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DROP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Descending scan so the lowest in-range slot is the last writer; misses hold idx/addr.
    always_comb begin
        hit_d      = 1'b0;
        hit_idx_d  = hit_idx_q;
        rom_addr_d = rom_addr_q;
        for (int i = N_GOLD - 1; i >= 0; i--) begin
            if (in_range_s[i]) begin
                hit_d      = 1'b1;
                hit_idx_d  = IDX_W'(i);
                rom_addr_d = off_addr_s[i];
            end else begin
                hit_d = hit_d;
            end
        end
    end

    // State registers; reset restores the default placement table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_GOLD; i++) begin
                pos_x_q[i] <= grid_to_x(DEF_GX[i], X_STEP, X_OFF);
                pos_y_q[i] <= grid_to_y(DEF_GY[i], Y_STEP, Y_OFF);
            end
            active_q      <= {N_GOLD{1'b1}};
            remaining_q   <= (IDX_W + 1)'(N_GOLD);
            state_q       <= ST_IDLE;
            collect_ack_q <= 1'b0;
            hit_q         <= 1'b0;
            hit_idx_q     <= {IDX_W{1'b0}};
            rom_addr_q    <= {ADDR_W{1'b0}};
        end else begin
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            active_q      <= active_d;
            remaining_q   <= remaining_d;
            state_q       <= state_d;
            collect_ack_q <= collect_ack_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            rom_addr_q    <= rom_addr_d;
        end
    end

    assign collect_ack = collect_ack_q;
    assign hit         = hit_q;
    assign hit_idx     = hit_idx_q;
    assign rom_addr    = rom_addr_q;
    assign active_mask = active_q;
    assign remaining   = remaining_q;

endmodule

// File: tb/tb_gold_sprite_engine.sv
// Self-checking bench for gold_sprite_engine at default parameters.
module tb_gold_sprite_engine;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic [10:0]       curr_x;
    logic [9:0]        curr_y;
    logic              pix_valid;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [3:0]        cfg_gx;
    logic [2:0]        cfg_gy;
    logic              collect_req;
    logic [IDX_W-1:0]  collect_idx;
    logic              collect_ack;
    logic              respawn;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] rom_addr;
    logic [9:0]        active_mask;
    logic [IDX_W:0]    remaining;

    gold_sprite_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .pix_valid   (pix_valid),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_gx      (cfg_gx),
        .cfg_gy      (cfg_gy),
        .collect_req (collect_req),
        .collect_idx (collect_idx),
        .collect_ack (collect_ack),
        .respawn     (respawn),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .rom_addr    (rom_addr),
        .active_mask (active_mask),
        .remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic        v;
        logic        h;
        logic [3:0]  idx;
        logic [10:0] addr;
    } vec_t;

    typedef struct {
        int          due;
        logic        h;
        logic [3:0]  idx;
        logic [10:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[12];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [3:0]  m_idx = 4'd0;
    logic [10:0] m_addr = 11'd0;
    int          acks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one pixel and queue what the output stage must show one edge later.
    task automatic drive_px(input logic [10:0] x, input logic [9:0] y, input logic v,
                            input logic h, input logic [3:0] idx, input logic [10:0] addr);
        exp_t e;
        @(negedge clk);
        curr_x    = x;
        curr_y    = y;
        pix_valid = v;
        if (h) begin
            m_idx  = idx;
            m_addr = addr;
        end
        e.due  = cyc + 1;
        e.h    = h;
        e.idx  = m_idx;
        e.addr = m_addr;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_collect(input logic [3:0] idx, input int hold, output int n_ack);
        n_ack = 0;
        @(negedge clk);
        collect_idx = idx;
        collect_req = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (collect_ack) n_ack++;
        end
        @(negedge clk);
        collect_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (collect_ack) n_ack++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : sb_check
        exp_t e;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("hit", 32'(hit), 32'(e.h));
            check("hit_idx", 32'(hit_idx), 32'(e.idx));
            check("rom_addr", 32'(rom_addr), 32'(e.addr));
        end
    end

    initial begin
        vecs[0]  = '{11'd262,  10'd442, 1'b1, 1'b1, 4'd0, 11'd0};
        vecs[1]  = '{11'd301,  10'd481, 1'b1, 1'b1, 4'd0, 11'd1599};
        vecs[2]  = '{11'd302,  10'd481, 1'b1, 1'b0, 4'd0, 11'd0};
        vecs[3]  = '{11'd262,  10'd482, 1'b1, 1'b0, 4'd0, 11'd0};
        vecs[4]  = '{11'd261,  10'd442, 1'b1, 1'b0, 4'd0, 11'd0};
        vecs[5]  = '{11'd136,  10'd334, 1'b1, 1'b1, 4'd1, 11'd0};
        vecs[6]  = '{11'd262,  10'd442, 1'b0, 1'b0, 4'd0, 11'd0};
        vecs[7]  = '{11'd900,  10'd120, 1'b1, 1'b1, 4'd2, 11'd88};
        vecs[8]  = '{11'd1183, 10'd49,  1'b1, 1'b1, 4'd7, 11'd1599};
        vecs[9]  = '{11'd1150, 10'd450, 1'b1, 1'b1, 4'd9, 11'd326};
        vecs[10] = '{11'd10,   10'd442, 1'b1, 1'b1, 4'd8, 11'd0};
        vecs[11] = '{11'd0,    10'd0,   1'b1, 1'b0, 4'd0, 11'd0};

        rst_n = 1'b0;
        curr_x = 11'd0; curr_y = 10'd0; pix_valid = 1'b0;
        cfg_we = 1'b0; cfg_idx = 4'd0; cfg_gx = 4'd0; cfg_gy = 3'd0;
        collect_req = 1'b0; collect_idx = 4'd0; respawn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_hit_idx", 32'(hit_idx), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ack", 32'(collect_ack), 32'd0);
        check("rst_mask", 32'(active_mask), 32'h3FF);
        check("rst_remaining", 32'(remaining), 32'd10);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            drive_px(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].h, vecs[i].idx, vecs[i].addr);
        settle();

        // Sweep across slot 0's last row and one pixel past its right edge.
        for (int x = 262; x <= 302; x++)
            drive_px(11'(x), 10'd442, 1'b1, (x < 302), 4'd0, (x < 302) ? 11'(x - 262) : 11'd0);
        settle();

        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_gx = 4'd2; cfg_gy = 3'd4;
        @(negedge clk);
        cfg_we = 1'b0;
        drive_px(11'd272, 10'd452, 1'b1, 1'b1, 4'd0, 11'd410);
        settle();

        do_collect(4'd0, 5, acks);
        check("collect0_acks", 32'(acks), 32'd1);
        check("collect0_mask0", 32'(active_mask[0]), 32'd0);
        check("collect0_remaining", 32'(remaining), 32'd9);
        drive_px(11'd272, 10'd452, 1'b1, 1'b1, 4'd1, 11'd410);
        settle();

        @(negedge clk); respawn = 1'b1;
        @(negedge clk); respawn = 1'b0;
        check("respawn_remaining", 32'(remaining), 32'd10);

        do_collect(4'd3, 2, acks);
        check("collect3a_acks", 32'(acks), 32'd1);
        check("collect3a_remaining", 32'(remaining), 32'd9);
        do_collect(4'd3, 2, acks);
        check("collect3b_acks", 32'(acks), 32'd1);
        check("collect3b_remaining", 32'(remaining), 32'd9);
        @(negedge clk);
        respawn = 1'b1; collect_req = 1'b1; collect_idx = 4'd3;
        @(posedge clk);
        #1;
        check("race_ack", 32'(collect_ack), 32'd0);
        check("race_remaining", 32'(remaining), 32'd10);
        check("race_mask", 32'(active_mask), 32'h3FF);
        @(negedge clk);
        respawn = 1'b0; collect_req = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset while a hit is showing.
        drive_px(11'd301, 10'd481, 1'b1, 1'b1, 4'd0, 11'd1599);
        @(posedge clk);
        #2;
        check("pre_rst_hit", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_hit", 32'(hit), 32'd0);
        check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("async_rst_hit_idx", 32'(hit_idx), 32'd0);
        m_idx = 4'd0;
        m_addr = 11'd0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_px(11'd140, 10'd340, 1'b1, 1'b1, 4'd1, 11'd244);
        drive_px(11'd272, 10'd452, 1'b1, 1'b1, 4'd0, 11'd410);
        settle();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gold_sprite_engine.md
Name: gold_sprite_engine

Overview:
- Parametrised gold-sprite position table and sprite-ROM address generator for the VGA renderer.
- Holds N_GOLD grid-placed sprites, each with a per-sprite active flag.
- Detects which live sprite covers the current scan pixel and emits a registered ROM address and hit index to the pixel mux.
- Positions are loadable at runtime; sprites can be collected (removed) and respawned.

Parameters:
- N_GOLD, 10, number of sprite slots (1..16)
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- X_STEP, 126, horizontal grid pitch in pixels
- Y_STEP, 108, vertical grid pitch in pixels
- X_OFF, 10, horizontal pixel offset of grid origin
- Y_OFF, 10, vertical pixel offset of grid origin
- IDX_W, clog2(N_GOLD), slot index width
- ADDR_W, clog2(SPR_W*SPR_H), ROM address width (11 at defaults)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- curr_x  in  11  current scan column
- curr_y  in  10  current scan row
- pix_valid  in  1  curr_x/curr_y are in the visible area
- cfg_we  in  1  write one slot's grid position
- cfg_idx  in  IDX_W  slot written
- cfg_gx  in  4  grid column
- cfg_gy  in  3  grid row
- collect_req  in  1  request removal of a slot (level, held until ack)
- collect_idx  in  IDX_W  slot to remove
- collect_ack  out  1  one-cycle acknowledge of collect_req
- respawn  in  1  pulse; re-activates all slots
- hit  out  1  registered: the pixel lies inside an active sprite
- hit_idx  out  IDX_W  registered: lowest-index sprite hit
- rom_addr  out  ADDR_W  registered sprite ROM address
- active_mask  out  N_GOLD  per-slot active flags
- remaining  out  IDX_W+1  count of active slots

Behaviour:
- Reset (rst_n low, async):
  - Slot i position = default table (2,4),(1,3),(7,1),(8,2),(5,4),(6,2),(2,1),(9,0),(0,4),(9,4) for i=0..9; slots beyond 9 take (0,0).
  - active_mask = all ones; remaining = N_GOLD.
  - hit = 0, hit_idx = 0, rom_addr = 0, collect_ack = 0.
- Position registers:
  - Store pixel coordinates: x = gx*X_STEP + X_OFF (11 bits), y = gy*Y_STEP + Y_OFF (10 bits). Computed once on write, not per pixel.
  - cfg_we writes the slot on the next edge. cfg_idx >= N_GOLD is ignored.
- Hit test (combinational stage):
  - Slot i is in range when pix_valid, active[i], x_i <= curr_x < x_i+SPR_W, and y_i <= curr_y < y_i+SPR_H.
  - Compares use 12/11-bit unsigned arithmetic, so x_i+SPR_W never wraps.
- Output stage (latency exactly 1 cycle from curr_x/curr_y):
  - Priority encoder selects the lowest in-range index.
  - rom_addr = (curr_x - x_sel) + SPR_W*(curr_y - y_sel), truncated to ADDR_W. Maximum value is SPR_W*SPR_H-1 = 1599 at defaults.
  - When no slot is in range: hit = 0, and rom_addr and hit_idx hold their last value.
- Collect FSM, states IDLE, ACK, WAIT_DROP:
  - IDLE: on collect_req, clear active[collect_idx], update remaining, assert collect_ack; go to ACK.
  - ACK: deassert ack; go to WAIT_DROP.
  - WAIT_DROP: stay until collect_req = 0, then IDLE. A held request is therefore acted on exactly once.
  - Collecting an already-inactive slot or an index >= N_GOLD still acks, with no state change.
- respawn:
  - Sets all active bits, sets remaining = N_GOLD, and forces the FSM to IDLE.
  - If respawn and a collect land in the same cycle, respawn wins and no ack is issued that cycle.
- cfg_we and collect on the same slot in the same cycle: both take effect.
- The active change takes effect for the hit test on the cycle after the edge that updates it.
- Reset mid-frame: outputs go to reset values immediately, with no partial-frame memory.

Decomposition:
- Package gold_pkg holds:
  - default grid table constants;
  - sprite geometry and grid parameter defaults;
  - the collect FSM state enum.
- One sub-module, gold_slot_hit: per-slot range compare and local offset generation, instantiated N_GOLD times. Priority encoding, the address register and the FSM stay at top level.

Test Plan:
- Reset, then scan the pixel at (262,442) -> next cycle hit=1, hit_idx=0, rom_addr=0. Pixel (301,481) -> rom_addr=1599.
- Pixel (262,442) with curr_x stepped to 302 -> hit drops to 0 one cycle after curr_x=302; rom_addr holds 39.
- cfg_we idx=1, gx=2, gy=4 (now overlapping slot 0), pixel (272,452) -> hit_idx=0 (lowest wins), rom_addr=410.
- collect_req idx=0 held 5 cycles -> exactly one collect_ack pulse; active_mask[0]=0; remaining=9. Same pixel then hits slot 1 with hit_idx=1.
- Collect slot 3 twice, then respawn in the same cycle as a third collect -> remaining goes 9, 9, then 10 with no ack; active_mask = 10'h3FF.
- Assert rst_n low mid-scan while hit=1 -> hit=0 and rom_addr=0 asynchronously; positions restored to the default table.
